tdm_demux: RTL and testbench



---
 rtl/tdm_demux_pkg.sv | 15 +
 rtl/tdm_demux_if.sv | 30 +++
 rtl/tdm_defs.vh | 11 +
 rtl/tdm_slot_dec.sv | 21 ++
 rtl/tdm_demux.sv | 151 +++++++++++++++
 tb/tb_tdm_demux.sv | 174 +++++++++++++++++
 6 files changed

// File: rtl/tdm_demux_pkg.sv
// Package for the TDM demultiplexer: state type and default parameters.
`include "tdm_defs.vh"

package tdm_demux_pkg;

    typedef enum logic {
        StHunt = `ST_HUNT,
        StLock = `ST_LOCK
    } tdm_state_e;

    localparam int unsigned DefDataW = `TDM_DATA_W_DEFAULT;
    localparam int unsigned DefCh    = `TDM_CH_DEFAULT;
    localparam int unsigned DefIdxW  = 4;

endpackage

// File: rtl/tdm_demux_if.sv
// Serial-in / frame-out bus of the TDM demultiplexer.
// master drives the serial stream, slave (the demux) returns frames and status.
interface tdm_demux_if
    import tdm_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CH     = DefCh,
    parameter int unsigned IDX_W  = DefIdxW
) ();

    logic [DATA_W-1:0]    din;
    logic                 din_valid;
    logic                 sync;
    logic [CH*DATA_W-1:0] out;
    logic                 out_valid;
    logic                 locked;
    logic [IDX_W-1:0]     ch_idx;
    logic                 err;

    modport master (
        output din, din_valid, sync,
        input  out, out_valid, locked, ch_idx, err
    );

    modport slave (
        input  din, din_valid, sync,
        output out, out_valid, locked, ch_idx, err
    );

endinterface

// File: rtl/tdm_defs.vh
// Shared definitions for tdm_demux: state encodings and default geometry.
`ifndef TDM_DEFS_VH
`define TDM_DEFS_VH

`define ST_HUNT 1'b0
`define ST_LOCK 1'b1

`define TDM_DATA_W_DEFAULT 8
`define TDM_CH_DEFAULT     2

`endif

// File: rtl/tdm_slot_dec.sv
// One-hot slot write-enable decoder; purely combinational.
module tdm_slot_dec #(
    parameter int unsigned CH    = 2,
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [CH-1:0]    we_o
);

    // Assert exactly the enable matching idx_i when a beat is accepted.
    always_comb begin
        we_o = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (en_i && (idx_i == IDX_W'(k))) begin
                we_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer and frame reassembler.
// Optional macro TDM_DEMUX_SYNC_CHECK_EN: check SYNC alignment while locked and
// pulse ERR on misalignment; when undefined ERR is tied low and the block free-runs.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CH     = DefCh,
    parameter int unsigned IDX_W  = DefIdxW
) (
    input  logic       clk_i,
    input  logic       rst_i,
    tdm_demux_if.slave bus_io
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CH - 1);

    tdm_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CH*DATA_W-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    // Channel CH-1 never needs storage: it goes straight from din into the frame.
    logic [DATA_W-1:0]    slot_q [CH-1];

    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [CH-1:0]        slot_we;
    logic                 frame_done;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic                 err_q, err_d;
`endif

    tdm_slot_dec #(
        .CH    (CH),
        .IDX_W (IDX_W)
    ) u_slot_dec (
        .idx_i (wr_idx),
        .en_i  (wr_en),
        .we_o  (slot_we)
    );

    // Alignment FSM: decides whether a beat is accepted, into which slot, and the next index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StHunt: begin
                if (bus_io.din_valid && bus_io.sync) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    idx_d   = IDX_W'(1);
                    state_d = StLock;
                end
            end
            StLock: begin
                if (bus_io.din_valid) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    if (bus_io.sync && (idx_q != '0)) begin
                        // Early SYNC: drop the partial frame and restart at slot 0.
                        err_d  = 1'b1;
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        idx_d  = IDX_W'(1);
                    end else if (!bus_io.sync && (idx_q == '0)) begin
                        // Missing SYNC: drop the beat and go back to hunting.
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = StHunt;
                    end else begin
                        wr_en = 1'b1;
                        idx_d = (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);
                    end
`else
                    wr_en = 1'b1;
                    idx_d = (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);
`endif
                end
            end
            default: begin
                state_d = StHunt;
                idx_d   = '0;
            end
        endcase
    end

    // Frame assembly: a write to the last channel completes the frame.
    always_comb begin
        frame_done  = slot_we[CH-1];
        out_d       = out_q;
        out_valid_d = frame_done;
        if (frame_done) begin
            for (int unsigned k = 0; k < CH - 1; k++) begin
                out_d[k*DATA_W +: DATA_W] = slot_q[k];
            end
            out_d[(CH-1)*DATA_W +: DATA_W] = bus_io.din;
        end
    end

    // Control and output registers; reset has priority over any incoming beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHunt;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // Slot storage for channels 0..CH-2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < CH - 1; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < CH - 1; k++) begin
                if (slot_we[k]) begin
                    slot_q[k] <= bus_io.din;
                end
            end
        end
    end

    assign bus_io.out       = out_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.locked    = (state_q == StLock);
    assign bus_io.ch_idx    = idx_q;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    assign bus_io.err       = err_q;
`else
    assign bus_io.err       = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with CH=2, DATA_W=8.
module tb_tdm_demux;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   ov_cnt;
    int   ov_mark;

    tdm_demux_if #(.DATA_W(8), .CH(2), .IDX_W(4)) bus ();

    tdm_demux #(
        .DATA_W (8),
        .CH     (2),
        .IDX_W  (4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat for one clock, then sample #1 after the edge.
    task automatic beat(input logic [7:0] d, input logic v, input logic s);
        bus.din       = d;
        bus.din_valid = v;
        bus.sync      = s;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        if (bus.out_valid === 1'b1) ov_cnt++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ov_cnt = 0;
        rst = 1'b1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.sync = 1'b0;

        // Reset for two cycles
        beat(8'h00, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_out", 32'(bus.out), 32'h0000);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_idx", 32'(bus.ch_idx), 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_err", 32'(bus.err), 0);

        // Hunt: unsynced beat discarded, then SYNC aligns
        beat(8'h11, 1'b1, 1'b0);
        chk("hunt_discard_locked", 32'(bus.locked), 0);
        chk("hunt_discard_idx", 32'(bus.ch_idx), 0);
        beat(8'hA5, 1'b1, 1'b1);
        chk("hunt_sync_locked", 32'(bus.locked), 1);
        chk("hunt_sync_idx", 32'(bus.ch_idx), 1);
        chk("hunt_sync_ov", 32'(bus.out_valid), 0);
        chk("hunt_sync_out", 32'(bus.out), 32'h0000);
        beat(8'h3C, 1'b1, 1'b0);
        chk("hunt_frame_ov", 32'(bus.out_valid), 1);
        chk("hunt_frame_out", 32'(bus.out), 32'h3CA5);
        chk("hunt_frame_idx", 32'(bus.ch_idx), 0);
        beat(8'h00, 1'b0, 1'b0);
        chk("hunt_pulse_end", 32'(bus.out_valid), 0);
        chk("hunt_out_hold", 32'(bus.out), 32'h3CA5);

        // Gaps: three idle cycles between the two beats
        ov_mark = ov_cnt;
        beat(8'hA5, 1'b1, 1'b1);
        chk("gap_idx1", 32'(bus.ch_idx), 1);
        beat(8'h00, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b1);
        beat(8'h00, 1'b0, 1'b0);
        chk("gap_idx_held", 32'(bus.ch_idx), 1);
        chk("gap_out_held", 32'(bus.out), 32'h3CA5);
        beat(8'h3C, 1'b1, 1'b0);
        chk("gap_idx0", 32'(bus.ch_idx), 0);
        chk("gap_out", 32'(bus.out), 32'h3CA5);
        beat(8'h00, 1'b0, 1'b0);
        chk("gap_pulses", 32'(ov_cnt - ov_mark), 1);

        // Back-to-back: four frames on consecutive cycles
        begin
            logic [15:0] prev;
            logic [7:0]  lo;
            logic [7:0]  hi;
            prev = 16'h3CA5;
            for (int i = 0; i < 4; i++) begin
                lo = 8'(2 * i + 1);
                hi = 8'(2 * i + 2);
                beat(lo, 1'b1, 1'b1);
                chk("b2b_half_ov", 32'(bus.out_valid), 0);
                chk("b2b_half_out", 32'(bus.out), 32'(prev));
                beat(hi, 1'b1, 1'b0);
                chk("b2b_full_ov", 32'(bus.out_valid), 1);
                chk("b2b_full_out", 32'(bus.out), 32'({hi, lo}));
                prev = {hi, lo};
            end
        end
        beat(8'h00, 1'b0, 1'b0);
        chk("b2b_idle_ov", 32'(bus.out_valid), 0);

`ifdef TDM_DEMUX_SYNC_CHECK_EN
        // Misaligned SYNC while locked
        beat(8'h99, 1'b1, 1'b1);
        chk("mis_idx1", 32'(bus.ch_idx), 1);
        beat(8'h77, 1'b1, 1'b1);
        chk("mis_early_err", 32'(bus.err), 1);
        chk("mis_early_ov", 32'(bus.out_valid), 0);
        chk("mis_early_idx", 32'(bus.ch_idx), 1);
        chk("mis_early_locked", 32'(bus.locked), 1);
        beat(8'h88, 1'b1, 1'b0);
        chk("mis_frame_out", 32'(bus.out), 32'h8877);
        chk("mis_frame_ov", 32'(bus.out_valid), 1);
        chk("mis_frame_err", 32'(bus.err), 0);
        beat(8'h44, 1'b1, 1'b0);
        chk("mis_late_err", 32'(bus.err), 1);
        chk("mis_late_locked", 32'(bus.locked), 0);
        chk("mis_late_idx", 32'(bus.ch_idx), 0);
        chk("mis_late_ov", 32'(bus.out_valid), 0);
        beat(8'h12, 1'b1, 1'b0);
        chk("mis_hunt_discard", 32'(bus.locked), 0);
        chk("mis_err_pulse_end", 32'(bus.err), 0);
`else
        // SYNC ignored while locked; ERR stays low
        beat(8'h55, 1'b1, 1'b0);
        chk("free_idx1", 32'(bus.ch_idx), 1);
        chk("free_err0", 32'(bus.err), 0);
        chk("free_locked", 32'(bus.locked), 1);
        beat(8'h66, 1'b1, 1'b1);
        chk("free_out", 32'(bus.out), 32'h6655);
        chk("free_ov", 32'(bus.out_valid), 1);
        chk("free_err1", 32'(bus.err), 0);
`endif

        // Reset mid-frame
        beat(8'hA1, 1'b1, 1'b1);
        chk("mid_pre_idx", 32'(bus.ch_idx), 1);
        rst = 1'b1;
        beat(8'hB2, 1'b1, 1'b0);
        rst = 1'b0;
        chk("mid_rst_out", 32'(bus.out), 32'h0000);
        chk("mid_rst_locked", 32'(bus.locked), 0);
        chk("mid_rst_idx", 32'(bus.ch_idx), 0);
        chk("mid_rst_ov", 32'(bus.out_valid), 0);
        beat(8'hC3, 1'b1, 1'b0);
        chk("mid_discard_locked", 32'(bus.locked), 0);
        chk("mid_discard_idx", 32'(bus.ch_idx), 0);
        chk("mid_discard_ov", 32'(bus.out_valid), 0);
        beat(8'hD4, 1'b1, 1'b1);
        beat(8'hE5, 1'b1, 1'b0);
        chk("mid_relock_out", 32'(bus.out), 32'hE5D4);
        chk("mid_relock_ov", 32'(bus.out_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
